// File: rtl/dual_input_conditioner.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : dual_input_conditioner
// Description : Two-channel input conditioner. Each raw asynchronous input is
//               synchronised through a SYNC_STAGES-deep flop chain and then
//               debounced by a four-state FSM that only accepts a new level
//               after DEBOUNCE_CYCLES consecutive identical samples.
//               Produces registered clean levels, one-cycle rise/fall pulses
//               and a glitch-free AND of the two clean levels.
// Ports       : clk      - system clock, rising edge
//               rst      - synchronous active-high reset
//               raw_a/b  - asynchronous raw inputs
//               a/b_clean- debounced levels (registered)
//               a/b_rise - one-cycle pulse on clean 0->1
//               a/b_fall - one-cycle pulse on clean 1->0
//               ab_and   - a_clean & b_clean, from registers only
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module dual_input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_a,
    input  logic raw_b,
    output logic a_clean,
    output logic b_clean,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall,
    output logic ab_and
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [1:0] c_ST_STABLE_LOW  = 2'd0;
    localparam logic [1:0] c_ST_PEND_HIGH   = 2'd1;
    localparam logic [1:0] c_ST_STABLE_HIGH = 2'd2;
    localparam logic [1:0] c_ST_PEND_LOW    = 2'd3;

    localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

    logic [1:0] w_raw;
    logic [1:0] w_clean;
    logic [1:0] w_rise;
    logic [1:0] w_fall;

    assign w_raw = {raw_b, raw_a};

    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   w_s;
        logic [1:0]             r_state;
        logic [1:0]             w_state_nxt;
        logic [CNT_W-1:0]       r_cnt;
        logic [CNT_W-1:0]       w_cnt_nxt;
        logic [CNT_W-1:0]       w_cnt_inc;
        logic                   w_clean_nxt;
        logic                   r_clean;
        logic                   r_rise;
        logic                   r_fall;

        // Synchroniser chain; only the last stage is ever looked at.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[gi]};
            end
        end

        assign w_s       = r_sync[SYNC_STAGES-1];
        assign w_cnt_inc = r_cnt + c_CNT_ONE;

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            case (r_state)
                c_ST_STABLE_LOW: begin
                    if (w_s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            w_state_nxt = c_ST_STABLE_HIGH;
                            w_cnt_nxt   = c_CNT_ZERO;
                        end else begin
                            w_state_nxt = c_ST_PEND_HIGH;
                            w_cnt_nxt   = c_CNT_ONE;
                        end
                    end
                end
                c_ST_PEND_HIGH: begin
                    // A low sample inside the pending window is a bounce.
                    if (!w_s) begin
                        w_state_nxt = c_ST_STABLE_LOW;
                        w_cnt_nxt   = c_CNT_ZERO;
                    end else if (w_cnt_inc == c_CNT_MAX) begin
                        w_state_nxt = c_ST_STABLE_HIGH;
                        w_cnt_nxt   = c_CNT_ZERO;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                    end
                end
                c_ST_STABLE_HIGH: begin
                    if (!w_s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            w_state_nxt = c_ST_STABLE_LOW;
                            w_cnt_nxt   = c_CNT_ZERO;
                        end else begin
                            w_state_nxt = c_ST_PEND_LOW;
                            w_cnt_nxt   = c_CNT_ONE;
                        end
                    end
                end
                c_ST_PEND_LOW: begin
                    if (w_s) begin
                        w_state_nxt = c_ST_STABLE_HIGH;
                        w_cnt_nxt   = c_CNT_ZERO;
                    end else if (w_cnt_inc == c_CNT_MAX) begin
                        w_state_nxt = c_ST_STABLE_LOW;
                        w_cnt_nxt   = c_CNT_ZERO;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_STABLE_LOW;
                    w_cnt_nxt   = c_CNT_ZERO;
                end
            endcase
        end

        // Clean level is high in both "accepted high" states, so a pending
        // change keeps the old level until it is confirmed.
        assign w_clean_nxt = (w_state_nxt == c_ST_STABLE_HIGH) ||
                             (w_state_nxt == c_ST_PEND_LOW);

        // Pulses are computed from the next clean value so they line up
        // with the cycle in which the new clean level first appears.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= c_ST_STABLE_LOW;
                r_cnt   <= c_CNT_ZERO;
                r_clean <= 1'b0;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_clean <= w_clean_nxt;
                r_rise  <= w_clean_nxt & ~r_clean;
                r_fall  <= ~w_clean_nxt & r_clean;
            end
        end

        assign w_clean[gi] = r_clean;
        assign w_rise[gi]  = r_rise;
        assign w_fall[gi]  = r_fall;
    end

    assign a_clean = w_clean[0];
    assign b_clean = w_clean[1];
    assign a_rise  = w_rise[0];
    assign a_fall  = w_fall[0];
    assign b_rise  = w_rise[1];
    assign b_fall  = w_fall[1];
    assign ab_and  = w_clean[0] & w_clean[1];

endmodule
`default_nettype wire

// File: tb/tb_dual_input_conditioner.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_dual_input_conditioner
// Description : Self-checking bench. Stimulus pushes expected pulse events
//               (instance, kind, edge number) into a queue; a monitor on the
//               falling edge pops and compares whenever a pulse is seen.
//               Three instances: defaults, S=3/D=1 and S=2/D=8.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_dual_input_conditioner;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic raw_a = 1'b0, raw_b = 1'b0;
    logic raw_a1 = 1'b0, raw_b1 = 1'b0;
    logic raw_a2 = 1'b0, raw_b2 = 1'b0;

    logic a_clean0, b_clean0, a_rise0, a_fall0, b_rise0, b_fall0, ab_and0;
    logic a_clean1, b_clean1, a_rise1, a_fall1, b_rise1, b_fall1, ab_and1;
    logic a_clean2, b_clean2, a_rise2, a_fall2, b_rise2, b_fall2, ab_and2;

    always #5 clk = ~clk;

    dual_input_conditioner u_dut0 (
        .clk(clk), .rst(rst), .raw_a(raw_a), .raw_b(raw_b),
        .a_clean(a_clean0), .b_clean(b_clean0),
        .a_rise(a_rise0), .a_fall(a_fall0),
        .b_rise(b_rise0), .b_fall(b_fall0), .ab_and(ab_and0)
    );

    dual_input_conditioner #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .raw_a(raw_a1), .raw_b(raw_b1),
        .a_clean(a_clean1), .b_clean(b_clean1),
        .a_rise(a_rise1), .a_fall(a_fall1),
        .b_rise(b_rise1), .b_fall(b_fall1), .ab_and(ab_and1)
    );

    dual_input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(8)) u_dut2 (
        .clk(clk), .rst(rst), .raw_a(raw_a2), .raw_b(raw_b2),
        .a_clean(a_clean2), .b_clean(b_clean2),
        .a_rise(a_rise2), .a_fall(a_fall2),
        .b_rise(b_rise2), .b_fall(b_fall2), .ab_and(ab_and2)
    );

    // Edge counter: after posedge n it holds n.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 a_rise, 1 a_fall, 2 b_rise, 3 b_fall
    typedef struct {
        int inst;
        int kind;
        int at;
    } exp_t;

    exp_t q[$];
    int n_pass  = 0;
    int n_total = 0;

    task automatic expect_pulse(input int inst, input int kind, input int at);
        exp_t e;
        e.inst = inst;
        e.kind = kind;
        e.at   = at;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic handle_pulse(input int inst, input int kind);
        exp_t e;
        n_total++;
        if (q.size() == 0) begin
            $display("FAIL pulse: unexpected inst%0d kind%0d at edge %0d, none expected",
                     inst, kind, cyc);
        end else begin
            e = q.pop_front();
            if (e.inst == inst && e.kind == kind && e.at == cyc) n_pass++;
            else $display("FAIL pulse: got inst%0d kind%0d at edge %0d, expected inst%0d kind%0d at edge %0d",
                          inst, kind, cyc, e.inst, e.kind, e.at);
        end
    endtask

    // Monitor: sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        logic [11:0] p;
        exp_t e;
        p = {b_fall2, b_rise2, a_fall2, a_rise2,
             b_fall1, b_rise1, a_fall1, a_rise1,
             b_fall0, b_rise0, a_fall0, a_rise0};
        // Anything due before this edge that was never seen is a miss.
        while (q.size() > 0 && q[0].at < cyc) begin
            e = q.pop_front();
            n_total++;
            $display("FAIL pulse: missing inst%0d kind%0d, expected at edge %0d, now edge %0d",
                     e.inst, e.kind, e.at, cyc);
        end
        for (int i = 0; i < 12; i++) begin
            if (p[i] === 1'b1) handle_pulse(i / 4, i % 4);
        end
    end

    initial begin
        int k;

        // 1: reset with inputs high, then release.
        raw_a = 1'b1;
        raw_b = 1'b1;
        tick(3);
        chk("reset_dut0_outputs", {25'd0, a_clean0, b_clean0, a_rise0, a_fall0, b_rise0, b_fall0, ab_and0}, 32'd0);
        chk("reset_dut1_clean", {30'd0, a_clean1, b_clean1}, 32'd0);
        chk("reset_dut2_clean", {30'd0, a_clean2, b_clean2}, 32'd0);
        rst = 1'b0;
        k = cyc;
        expect_pulse(0, 0, k + 6);
        expect_pulse(0, 2, k + 6);
        tick(5);
        chk("t1_a_clean_before", {31'd0, a_clean0}, 32'd0);
        chk("t1_ab_and_before", {31'd0, ab_and0}, 32'd0);
        tick(1);
        chk("t1_a_clean_after", {31'd0, a_clean0}, 32'd1);
        chk("t1_b_clean_after", {31'd0, b_clean0}, 32'd1);
        chk("t1_ab_and_after", {31'd0, ab_and0}, 32'd1);
        tick(4);

        // 2: return to low, short 3-cycle pulse rejected, then long high accepted.
        raw_a = 1'b0;
        raw_b = 1'b0;
        k = cyc;
        expect_pulse(0, 1, k + 6);
        expect_pulse(0, 3, k + 6);
        tick(10);
        raw_a = 1'b1;
        tick(3);
        raw_a = 1'b0;
        tick(3);
        chk("t2_short_pulse_clean", {31'd0, a_clean0}, 32'd0);
        tick(7);
        chk("t2_short_pulse_clean_late", {31'd0, a_clean0}, 32'd0);
        raw_a = 1'b1;
        k = cyc;
        expect_pulse(0, 0, k + 6);
        tick(10);

        // 3: bounce on b: high 2, low 1, high 6.
        raw_b = 1'b1;
        tick(2);
        raw_b = 1'b0;
        tick(1);
        raw_b = 1'b1;
        k = cyc;
        expect_pulse(0, 2, k + 6);
        tick(5);
        chk("t3_b_clean_early", {31'd0, b_clean0}, 32'd0);
        tick(1);
        chk("t3_b_clean_settled", {31'd0, b_clean0}, 32'd1);
        tick(4);

        // 4: drop a, reset while its fall is still pending.
        raw_a = 1'b0;
        tick(4);
        rst = 1'b1;
        tick(1);
        chk("t4_a_clean_after_rst", {31'd0, a_clean0}, 32'd0);
        chk("t4_b_clean_after_rst", {31'd0, b_clean0}, 32'd0);
        rst = 1'b0;
        k = cyc;
        expect_pulse(0, 2, k + 6);
        tick(12);
        chk("t4_a_clean_stays_low", {31'd0, a_clean0}, 32'd0);

        // 5: simultaneous changes on both channels.
        raw_b = 1'b0;
        k = cyc;
        expect_pulse(0, 3, k + 6);
        tick(10);
        raw_a = 1'b1;
        raw_b = 1'b1;
        k = cyc;
        expect_pulse(0, 0, k + 6);
        expect_pulse(0, 2, k + 6);
        tick(5);
        chk("t5_ab_and_pre_rise", {31'd0, ab_and0}, 32'd0);
        tick(1);
        chk("t5_ab_and_high", {31'd0, ab_and0}, 32'd1);
        tick(4);
        raw_a = 1'b0;
        raw_b = 1'b0;
        k = cyc;
        expect_pulse(0, 1, k + 6);
        expect_pulse(0, 3, k + 6);
        tick(5);
        chk("t5_ab_and_pre_fall", {31'd0, ab_and0}, 32'd1);
        tick(1);
        chk("t5_ab_and_low", {31'd0, ab_and0}, 32'd0);
        tick(4);

        // 6a: SYNC_STAGES=3, DEBOUNCE_CYCLES=1 -- 1-cycle pulse is accepted.
        raw_a1 = 1'b1;
        k = cyc;
        expect_pulse(1, 0, k + 4);
        expect_pulse(1, 1, k + 5);
        tick(1);
        raw_a1 = 1'b0;
        tick(10);
        raw_a1 = 1'b1;
        k = cyc;
        expect_pulse(1, 0, k + 4);
        tick(8);
        chk("t6_dut1_clean_high", {31'd0, a_clean1}, 32'd1);
        raw_a1 = 1'b0;
        k = cyc;
        expect_pulse(1, 1, k + 4);
        tick(8);

        // 6b: SYNC_STAGES=2, DEBOUNCE_CYCLES=8 -- 1-cycle pulse is rejected.
        raw_a2 = 1'b1;
        tick(1);
        raw_a2 = 1'b0;
        tick(14);
        chk("t6_dut2_short_rejected", {31'd0, a_clean2}, 32'd0);
        raw_a2 = 1'b1;
        k = cyc;
        expect_pulse(2, 0, k + 10);
        tick(9);
        chk("t6_dut2_clean_early", {31'd0, a_clean2}, 32'd0);
        tick(5);
        raw_a2 = 1'b0;
        k = cyc;
        expect_pulse(2, 1, k + 10);
        tick(14);

        tick(2);
        chk("queue_drained", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
